// File: rtl/compuerta_param.sv
// compuerta_param: PIN-gated parking barrier controller, one instance per gate.
//
// Sits between the keypad/vehicle sensors and the barrier actuator/alarm panel.
// A vehicle arriving at a closed gate arms the keypad; the correct PIN opens the
// barrier; repeated wrong entries raise the alarm; a second vehicle following
// through an open barrier locks the gate until a correct PIN is entered again.
// The barrier is closed again if it stays open too long without a crossing.
//
// Ports:
//   Clk       in   1      clock, rising edge
//   Reset     in   1      asynchronous, active-high
//   Vehiculo  in   1      vehicle present at gate
//   Termino   in   1      vehicle finished crossing (pulse)
//   enterPin  in   1      enter key level; only a 0->1 edge is a press
//   Pin       in   PIN_W  keypad value, compared on press
//   cfg_we    in   1      load cfg_pin into the stored PIN (only while closed)
//   cfg_pin   in   PIN_W  new PIN value
//   Cerrado   out  1      barrier closed
//   Abierto   out  1      barrier open
//   Alarma    out  1      wrong-PIN alarm
//   Bloqueo   out  1      tailgating lock
//   Intentos  out  CNT_W  consecutive wrong entries, saturating
//   Timeout   out  1      one-cycle pulse when the open timeout expires
//
// States:
//   state   | meaning
//   CERRADO | barrier closed, no vehicle waiting
//   ESPERA  | vehicle present, waiting for a PIN
//   ALARMA  | too many wrong PINs, waiting for the correct one
//   ABIERTO | barrier open, waiting for the crossing to finish
//   BLOQUEO | tailgating detected, waiting for the correct PIN

module compuerta_param #(
  parameter int               PIN_W        = 8,
  parameter logic [PIN_W-1:0] PIN_DEFAULT  = PIN_W'(8'h10),
  parameter int               MAX_INTENTOS = 3,
  parameter int               TIMEOUT      = 64,
  parameter int               CNT_W        = $clog2(MAX_INTENTOS + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Vehiculo,
  input  logic             Termino,
  input  logic             enterPin,
  input  logic [PIN_W-1:0] Pin,
  input  logic             cfg_we,
  input  logic [PIN_W-1:0] cfg_pin,
  output logic             Cerrado,
  output logic             Abierto,
  output logic             Alarma,
  output logic             Bloqueo,
  output logic [CNT_W-1:0] Intentos,
  output logic             Timeout
);

  localparam logic [2:0] CERRADO = 3'd0;
  localparam logic [2:0] ESPERA  = 3'd1;
  localparam logic [2:0] ALARMA  = 3'd2;
  localparam logic [2:0] ABIERTO = 3'd3;
  localparam logic [2:0] BLOQUEO = 3'd4;

  // The timer only ever has to reach TIMEOUT-1, so it needs clog2(TIMEOUT) bits.
  localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit               TMR_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INTENTOS);

  logic [2:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [PIN_W-1:0] pin_q, pin_d;
  logic             enter_q;
  logic             to_q, to_d;

  logic             press;
  logic             ok;
  logic             bad;
  logic [CNT_W-1:0] cnt_inc;

  // A held key counts once: a press needs the key to have been low at the
  // previous sample.
  assign press   = enterPin & ~enter_q;
  assign ok      = press & (Pin == pin_q);
  assign bad     = press & ~ok;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    pin_d = pin_q;
    tmr_d = '0;
    to_d  = 1'b0;

    // Presses are ignored while closed, so a same-cycle press never sees the
    // new PIN; loading is refused in every other state.
    if ((st_q == CERRADO) && cfg_we) begin
      pin_d = cfg_pin;
    end

    case (st_q)
      CERRADO: begin
        if (Vehiculo) begin
          st_d = ESPERA;
        end
      end
      ESPERA: begin
        if (!Vehiculo) begin
          st_d = CERRADO;
        end else if (ok) begin
          st_d  = ABIERTO;
          cnt_d = '0;
        end else if (bad) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            st_d = ALARMA;
          end
        end
      end
      ALARMA: begin
        if (ok) begin
          st_d  = ABIERTO;
          cnt_d = '0;
        end else if (bad) begin
          cnt_d = cnt_inc;
        end
      end
      ABIERTO: begin
        // A finished crossing beats an expiring timer in the same cycle.
        if (Termino) begin
          st_d = Vehiculo ? BLOQUEO : CERRADO;
        end else if (TMR_EN && (tmr_q == TMR_LAST)) begin
          to_d = 1'b1;
          st_d = Vehiculo ? ESPERA : CERRADO;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      BLOQUEO: begin
        if (ok) begin
          st_d  = ABIERTO;
          cnt_d = '0;
        end
      end
      default: begin
        st_d = CERRADO;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st_q    <= CERRADO;
      cnt_q   <= '0;
      tmr_q   <= '0;
      pin_q   <= PIN_DEFAULT;
      enter_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      pin_q   <= pin_d;
      enter_q <= enterPin;
      to_q    <= to_d;
    end
  end

  assign Abierto  = (st_q == ABIERTO);
  assign Cerrado  = ~Abierto;
  assign Alarma   = (st_q == ALARMA);
  assign Bloqueo  = (st_q == BLOQUEO);
  assign Intentos = cnt_q;
  assign Timeout  = to_q;

endmodule
